// File: rtl/keypad_scan_if.sv
// ---------------------------------------------------------------------------
// keypad_scan_if
// Purpose : Bundles the keypad-facing pins and the decoded key outputs of the
//           keypad scanner. Clock and reset are plain ports on the modules.
// Signals : JAin       [3:0] keypad rows, pulled up, low = key closed
//           JAout      [3:0] keypad columns, exactly one bit low
//           outcode    [3:0] code of the last accepted key
//           key_valid        high while an accepted key is held down
//           key_strobe       one-cycle pulse when a new key is accepted
// Modports: master = the scanner (drives columns and key outputs)
//           slave  = the keypad / downstream consumer side
// ---------------------------------------------------------------------------
interface keypad_scan_if;
  logic [3:0] JAin;
  logic [3:0] JAout;
  logic [3:0] outcode;
  logic       key_valid;
  logic       key_strobe;

  modport master (
    input  JAin,
    output JAout,
    output outcode,
    output key_valid,
    output key_strobe
  );

  modport slave (
    output JAin,
    input  JAout,
    input  outcode,
    input  key_valid,
    input  key_strobe
  );
endinterface

// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan
// Purpose : Scans a 4x4 matrix keypad by driving one column low at a time,
//           samples the synchronised rows at the end of each column dwell and
//           debounces whole-keypad scans before accepting a key press/release.
// Params  : SCAN_DIV        clk cycles each column stays driven (>= 4)
//           DEBOUNCE_SCANS  identical consecutive scans needed to accept
// Ports   : clk    system clock, rising edge
//           reset  asynchronous, active-low reset
//           kp     keypad_scan_if.master (JAin, JAout, outcode, key_valid,
//                  key_strobe)
// ---------------------------------------------------------------------------
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          reset,
  keypad_scan_if.master kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_FULL    = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} colState_t;

  // A scan result: found=0 means NONE, and code is then always zero so that
  // whole-struct equality compares NONE correctly.
  typedef struct packed {
    logic       found;
    logic [3:0] code;
  } scanRes_t;

  colState_t     r_col;
  colState_t     w_nextCol;
  logic [DW-1:0] r_dwell;
  logic          w_sampleNow;
  logic [3:0]    r_rowMeta;
  logic [3:0]    r_rowSync;
  logic [3:0]    r_jaOut;
  scanRes_t      r_scanAcc;
  scanRes_t      r_scanDone;
  scanRes_t      w_scanBase;
  scanRes_t      w_scanNext;
  logic          r_evalPending;
  scanRes_t      r_cand;
  logic [CW-1:0] r_dbCount;
  logic [CW-1:0] w_newCount;
  logic [3:0]    r_outcode;
  logic          r_keyValid;
  logic          r_keyStrobe;

  // Physical key legend: row r, column c -> hex key code.
  function automatic logic [3:0] keyCode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchroniser: the keypad rows are asynchronous mechanical inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rowMeta <= 4'hF;
      r_rowSync <= 4'hF;
    end else begin
      r_rowMeta <= kp.JAin;
      r_rowSync <= r_rowMeta;
    end
  end

  // Column FSM state register, dwell counter and registered column drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col   <= COL0;
      r_dwell <= '0;
      r_jaOut <= 4'b1110;
    end else begin
      r_col   <= w_nextCol;
      r_dwell <= w_sampleNow ? '0 : r_dwell + DW'(1);
      r_jaOut <= ~(4'b0001 << w_nextCol);
    end
  end

  // Column advance: the rows are sampled on the last dwell cycle, and the
  // next column is driven from the following cycle.
  always_comb begin
    w_sampleNow = (r_dwell == DWELL_LAST);
    w_nextCol   = r_col;
    if (w_sampleNow) begin
      case (r_col)
        COL0:    w_nextCol = COL1;
        COL1:    w_nextCol = COL2;
        COL2:    w_nextCol = COL3;
        default: w_nextCol = COL0;
      endcase
    end
  end

  // Scan accumulator: column 0 starts a fresh scan, and only the first low row
  // seen is kept, giving lowest-column-then-lowest-row priority. The loop runs
  // downwards so the lowest low row is the last assignment.
  always_comb begin
    w_scanBase = (r_col == COL0) ? scanRes_t'('0) : r_scanAcc;
    w_scanNext = w_scanBase;
    if (!w_scanBase.found) begin
      for (int r = 3; r >= 0; r--) begin
        if (!r_rowSync[r]) begin
          w_scanNext.found = 1'b1;
          w_scanNext.code  = keyCode(2'(r), r_col);
        end
      end
    end
  end

  // Debounce count for the finished scan: same result extends the run
  // (saturating), a different result restarts it at one.
  always_comb begin
    if (r_scanDone == r_cand) begin
      w_newCount = (r_dbCount == DB_FULL) ? DB_FULL : r_dbCount + CW'(1);
    end else begin
      w_newCount = CW'(1);
    end
  end

  // Scan capture and end-of-scan evaluation. Evaluation happens the cycle
  // after the column 3 sample. A saturated run of a held key matches the
  // accepted code, so a held key strobes only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scanAcc     <= '0;
      r_scanDone    <= '0;
      r_evalPending <= 1'b0;
      r_cand        <= '0;
      r_dbCount     <= '0;
      r_outcode     <= 4'h0;
      r_keyValid    <= 1'b0;
      r_keyStrobe   <= 1'b0;
    end else begin
      r_evalPending <= 1'b0;
      r_keyStrobe   <= 1'b0;
      if (w_sampleNow) begin
        r_scanAcc <= w_scanNext;
        if (r_col == COL3) begin
          r_scanDone    <= w_scanNext;
          r_evalPending <= 1'b1;
        end
      end
      if (r_evalPending) begin
        r_cand    <= r_scanDone;
        r_dbCount <= w_newCount;
        if (w_newCount == DB_FULL) begin
          if (r_scanDone.found) begin
            if (!r_keyValid || (r_scanDone.code != r_outcode)) begin
              r_outcode   <= r_scanDone.code;
              r_keyValid  <= 1'b1;
              r_keyStrobe <= 1'b1;
            end
          end else begin
            r_keyValid <= 1'b0;
          end
        end
      end
    end
  end

  assign kp.JAout      = r_jaOut;
  assign kp.outcode    = r_outcode;
  assign kp.key_valid  = r_keyValid;
  assign kp.key_strobe = r_keyStrobe;

endmodule

// File: tb/tb_keypad_scan.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan
// Purpose : Self-checking bench for keypad_scan with a behavioural 4x4 keypad
//           that pulls row r low while column c is driven low and key (r,c)
//           is held. Runs with SCAN_DIV=8, DEBOUNCE_SCANS=3.
// ---------------------------------------------------------------------------
module tb_keypad_scan;

  localparam int SCAN_DIV       = 8;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int SCAN_CYCLES    = 4 * SCAN_DIV;
  localparam int STROBE_BOUND   = (DEBOUNCE_SCANS + 1) * SCAN_CYCLES + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keysHeld;
  logic [3:0]  rowModel;
  int          checks   = 0;
  int          failures = 0;

  keypad_scan_if kpIf ();

  keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kpIf.master)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Keypad matrix model: keysHeld bit r*4+c closes the switch at row r, column c.
  always_comb begin
    rowModel = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keysHeld[r*4+c] && !kpIf.JAout[c]) rowModel[r] = 1'b0;
      end
    end
  end
  assign kpIf.JAin = rowModel;

  // Runaway guard in case a bounded wait is itself broken.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reset values while reset is held low.
  task automatic test_reset;
    keysHeld = '0;
    reset    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (kpIf.JAout !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL reset_JAout: got %b expected 1110", kpIf.JAout);
    end
    checks++;
    if (kpIf.outcode !== 4'h0) begin
      failures++;
      $display("[TB] FAIL reset_outcode: got %h expected 0", kpIf.outcode);
    end
    checks++;
    if (kpIf.key_valid !== 1'b0 || kpIf.key_strobe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got valid=%b strobe=%b expected 0 0",
               kpIf.key_valid, kpIf.key_strobe);
    end
    reset = 1'b1;
  endtask

  // No key: column walk 1110,1101,1011,0111 every SCAN_DIV cycles, outputs idle.
  task automatic test_idle_scan;
    logic [3:0] one;
    logic [3:0] expCol;
    int         activity;
    one      = 4'b0001;
    activity = 0;
    for (int k = 1; k <= 4 * SCAN_CYCLES; k++) begin
      @(negedge clk);
      expCol = ~(one << ((k / SCAN_DIV) % 4));
      checks++;
      if (kpIf.JAout !== expCol) begin
        failures++;
        $display("[TB] FAIL idle_JAout cycle %0d: got %b expected %b", k, kpIf.JAout, expCol);
      end
      if (kpIf.key_strobe !== 1'b0 || kpIf.key_valid !== 1'b0 || kpIf.outcode !== 4'h0)
        activity++;
    end
    checks++;
    if (activity !== 0) begin
      failures++;
      $display("[TB] FAIL idle_outputs: got %0d active cycles expected 0", activity);
    end
  endtask

  // Hold r1,c2 (key 6): one strobe inside the latency bound, then no more.
  task automatic test_single_key;
    int strobes;
    int waited;
    int extra;
    keysHeld       = '0;
    keysHeld[1*4+2] = 1'b1;
    strobes = 0;
    waited  = 0;
    while (strobes == 0 && waited < STROBE_BOUND) begin
      @(negedge clk);
      waited++;
      if (kpIf.key_strobe === 1'b1) strobes++;
    end
    checks++;
    if (strobes !== 1) begin
      failures++;
      $display("[TB] FAIL key6_strobe: got %0d strobes in %0d cycles expected 1", strobes, STROBE_BOUND);
    end
    checks++;
    if (waited < 2 * SCAN_CYCLES) begin
      failures++;
      $display("[TB] FAIL key6_latency_min: got %0d cycles expected >= %0d", waited, 2 * SCAN_CYCLES);
    end
    checks++;
    if (kpIf.outcode !== 4'h6 || kpIf.key_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL key6_outputs: got code=%h valid=%b expected 6 1", kpIf.outcode, kpIf.key_valid);
    end
    extra = 0;
    repeat (3 * SCAN_CYCLES) begin
      @(negedge clk);
      if (kpIf.key_strobe === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0 || kpIf.key_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL key6_held: got extra=%0d valid=%b expected 0 1", extra, kpIf.key_valid);
    end
  endtask

  // Release: key_valid drops only after enough NONE scans, outcode is held.
  task automatic test_release;
    int  waited;
    int  strobes;
    logic early;
    keysHeld = '0;
    waited   = 0;
    strobes  = 0;
    early    = 1'b0;
    while (kpIf.key_valid === 1'b1 && waited < STROBE_BOUND) begin
      @(negedge clk);
      waited++;
      if (kpIf.key_strobe === 1'b1) strobes++;
      if (kpIf.key_valid === 1'b0 && waited < 2 * SCAN_CYCLES) early = 1'b1;
    end
    checks++;
    if (kpIf.key_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release_valid: got %b after %0d cycles expected 0", kpIf.key_valid, waited);
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release_early: got drop at %0d cycles expected >= %0d", waited, 2 * SCAN_CYCLES);
    end
    checks++;
    if (strobes !== 0 || kpIf.outcode !== 4'h6) begin
      failures++;
      $display("[TB] FAIL release_outputs: got strobes=%0d code=%h expected 0 6", strobes, kpIf.outcode);
    end
  endtask

  // Bounce: F (r3,c1) held for only two scans must leave outputs untouched.
  task automatic test_glitch;
    int strobes;
    int validHigh;
    strobes   = 0;
    validHigh = 0;
    keysHeld        = '0;
    keysHeld[3*4+1] = 1'b1;
    repeat (2 * SCAN_CYCLES) begin
      @(negedge clk);
      if (kpIf.key_strobe === 1'b1) strobes++;
      if (kpIf.key_valid === 1'b1) validHigh++;
    end
    keysHeld = '0;
    repeat (4 * SCAN_CYCLES) begin
      @(negedge clk);
      if (kpIf.key_strobe === 1'b1) strobes++;
      if (kpIf.key_valid === 1'b1) validHigh++;
    end
    checks++;
    if (strobes !== 0 || validHigh !== 0) begin
      failures++;
      $display("[TB] FAIL glitch_flags: got strobes=%0d validCycles=%0d expected 0 0", strobes, validHigh);
    end
    checks++;
    if (kpIf.outcode !== 4'h6) begin
      failures++;
      $display("[TB] FAIL glitch_outcode: got %h expected 6", kpIf.outcode);
    end
  endtask

  // Two keys: r0,c0 (1) wins over r2,c3 (C); releasing 1 moves straight to C.
  task automatic test_back_to_back;
    int   strobes;
    int   waited;
    logic dropped;
    keysHeld        = '0;
    keysHeld[0*4+0] = 1'b1;
    keysHeld[2*4+3] = 1'b1;
    strobes = 0;
    waited  = 0;
    while (strobes == 0 && waited < STROBE_BOUND) begin
      @(negedge clk);
      waited++;
      if (kpIf.key_strobe === 1'b1) strobes++;
    end
    checks++;
    if (strobes !== 1 || kpIf.outcode !== 4'h1 || kpIf.key_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL multi_first: got strobes=%0d code=%h valid=%b expected 1 1 1",
               strobes, kpIf.outcode, kpIf.key_valid);
    end
    keysHeld[0*4+0] = 1'b0;
    strobes = 0;
    waited  = 0;
    dropped = 1'b0;
    while (strobes == 0 && waited < STROBE_BOUND) begin
      @(negedge clk);
      waited++;
      if (kpIf.key_strobe === 1'b1) strobes++;
      if (kpIf.key_valid !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (strobes !== 1 || kpIf.outcode !== 4'hC) begin
      failures++;
      $display("[TB] FAIL multi_second: got strobes=%0d code=%h expected 1 C", strobes, kpIf.outcode);
    end
    checks++;
    if (dropped !== 1'b0) begin
      failures++;
      $display("[TB] FAIL multi_valid_held: got valid drop expected key_valid held at 1");
    end
  endtask

  // Reset in the middle of column 2 with C still held, then re-accept once.
  task automatic test_reset_mid_scan;
    int strobes;
    int waited;
    int extra;
    waited = 0;
    while (kpIf.JAout !== 4'b1011 && waited < 2 * SCAN_CYCLES) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (kpIf.JAout !== 4'b1011) begin
      failures++;
      $display("[TB] FAIL midreset_reach_col2: got %b expected 1011", kpIf.JAout);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (kpIf.JAout !== 4'b1110 || kpIf.outcode !== 4'h0 ||
        kpIf.key_valid !== 1'b0 || kpIf.key_strobe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_async: got JAout=%b code=%h valid=%b strobe=%b expected 1110 0 0 0",
               kpIf.JAout, kpIf.outcode, kpIf.key_valid, kpIf.key_strobe);
    end
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    strobes = 0;
    waited  = 0;
    while (strobes == 0 && waited < STROBE_BOUND) begin
      @(negedge clk);
      waited++;
      if (kpIf.key_strobe === 1'b1) strobes++;
    end
    checks++;
    if (strobes !== 1 || kpIf.outcode !== 4'hC || kpIf.key_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_reaccept: got strobes=%0d code=%h valid=%b expected 1 C 1",
               strobes, kpIf.outcode, kpIf.key_valid);
    end
    extra = 0;
    repeat (3 * SCAN_CYCLES) begin
      @(negedge clk);
      if (kpIf.key_strobe === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("[TB] FAIL midreset_single: got %0d extra strobes expected 0", extra);
    end
  endtask

  // Scenario sequence; each task leaves the keypad in the state the next expects.
  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_release();
    test_glitch();
    test_back_to_back();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
